// File: rtl/cic_comp_fir_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cic_comp_fir_pkg
// Description : Shared FSM encoding, default compensation coefficient table
//               and elaboration helpers for the CIC compensation FIR.
// Revision    : 1.0 - initial release
// ============================================================================
package cic_comp_fir_pkg;

    // FSM encoding: IDLE, MAC, ROUND, OUT
    typedef logic [1:0] state_t;
    localparam state_t c_st_idle  = 2'd0;
    localparam state_t c_st_mac   = 2'd1;
    localparam state_t c_st_round = 2'd2;
    localparam state_t c_st_out   = 2'd3;

    // Symmetric droop-compensation taps, Q1.15; the sum is 32768 for unity DC gain.
    localparam int c_coef_len = 32;
    localparam logic signed [15:0] c_coef_table [c_coef_len] = '{
        -16'sd10,  -16'sd20,  -16'sd30,  -16'sd25,    16'sd0,   16'sd40,
         16'sd80,  16'sd100,   16'sd60,  -16'sd50, -16'sd200, -16'sd350,
        -16'sd300, 16'sd200, 16'sd1500, 16'sd15389,
         16'sd15389, 16'sd1500, 16'sd200, -16'sd300, -16'sd350, -16'sd200,
        -16'sd50,  16'sd60,  16'sd100,   16'sd80,   16'sd40,    16'sd0,
        -16'sd25, -16'sd30,  -16'sd20,  -16'sd10
    };

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic logic signed [15:0] coef_at(input int k);
        logic [4:0] idx;
        idx = k[4:0];
        if (k < 0 || k >= c_coef_len) begin
            return '0;
        end
        return c_coef_table[idx];
    endfunction

endpackage
`default_nettype wire

// File: rtl/cic_comp_coef_rom.sv
`default_nettype none
// ============================================================================
// Module      : cic_comp_coef_rom
// Description : Coefficient ROM with a registered read (one cycle latency).
// Revision    : 1.0 - initial release
// ============================================================================
module cic_comp_coef_rom
    import cic_comp_fir_pkg::*;
#(
    parameter int COEF_WIDTH = 16,
    parameter int DEPTH      = 32,
    parameter int AW         = 5
) (
    input  logic                         clk,
    input  logic [AW-1:0]                i_addr,
    output logic signed [COEF_WIDTH-1:0] o_coef
);

    always_ff @(posedge clk) begin
        if (int'(i_addr) < DEPTH) begin
            o_coef <= COEF_WIDTH'(coef_at(int'(i_addr)));
        end else begin
            o_coef <= '0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cic_comp_fir.sv
`default_nettype none
// ============================================================================
// Module      : cic_comp_fir
// Description : CIC droop-compensation FIR, sequential single-multiplier MAC,
//               optional 2:1 decimation, rounded/saturated valid/ready output.
//               Build option: CIC_COMP_FIR_SYMMETRIC_EN folds symmetric taps.
// Revision    : 1.0 - initial release
// ============================================================================
module cic_comp_fir
    import cic_comp_fir_pkg::*;
#(
    parameter int IN_WIDTH   = 32,
    parameter int OUT_WIDTH  = 16,
    parameter int COEF_WIDTH = 16,
    parameter int TAPS       = 32,
    parameter int ACC_WIDTH  = 56,
    parameter int SHIFT      = 15,
    parameter int DECIM      = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 in_valid,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    input  logic                 clr_status,
    output logic                 overrun,
    output logic                 sat
);

`ifdef CIC_COMP_FIR_SYMMETRIC_EN
    localparam int c_mac_cycles = TAPS / 2;
`else
    localparam int c_mac_cycles = TAPS;
`endif
    localparam int c_aw = clog2(TAPS);
    localparam int c_xw = IN_WIDTH + 1;
    localparam int c_pw = c_xw + COEF_WIDTH;
    localparam logic [c_aw-1:0] c_last_ptr = c_aw'(TAPS - 1);
    localparam logic [c_aw-1:0] c_mac_last = c_aw'(c_mac_cycles - 1);
    localparam bit c_no_decim = (DECIM == 1);
    localparam logic signed [ACC_WIDTH-1:0] c_half    = ACC_WIDTH'(64'sd1 <<< (SHIFT - 1));
    localparam logic signed [ACC_WIDTH-1:0] c_out_max = ACC_WIDTH'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
    localparam logic signed [ACC_WIDTH-1:0] c_out_min = ~c_out_max;

    state_t                        r_state;
    logic signed [IN_WIDTH-1:0]    r_line [TAPS];
    logic [c_aw-1:0]               r_wptr;
    logic [c_aw-1:0]               r_rptr_a;
    logic [c_aw-1:0]               r_k;
    logic                          r_phase;
    logic                          r_pend_valid;
    logic signed [IN_WIDTH-1:0]    r_pend_data;
    logic signed [ACC_WIDTH-1:0]   r_acc;
    logic signed [OUT_WIDTH-1:0]   r_result;
    logic signed [OUT_WIDTH-1:0]   r_out_data;
    logic                          r_out_valid;
    logic                          r_overrun;
    logic                          r_sat;

    logic                          w_idle;
    logic                          w_accept;
    logic signed [IN_WIDTH-1:0]    w_accept_data;
    logic                          w_phase_wrap;
    logic                          w_trigger;
    logic [c_aw-1:0]               w_wptr_next;
    logic [c_aw-1:0]               w_rptr_a_dec;
    logic [c_aw-1:0]               w_rom_addr;
    logic signed [COEF_WIDTH-1:0]  w_coef;
    logic signed [IN_WIDTH-1:0]    w_xa;
    logic signed [c_xw-1:0]        w_x_op;
    logic signed [c_pw-1:0]        w_x_ext;
    logic signed [c_pw-1:0]        w_c_ext;
    logic signed [c_pw-1:0]        w_prod;
    logic signed [ACC_WIDTH-1:0]   w_prod_ext;
    logic signed [ACC_WIDTH-1:0]   w_sum;
    logic signed [ACC_WIDTH-1:0]   w_shifted;
    logic                          w_clip_hi;
    logic                          w_clip_lo;
    logic signed [OUT_WIDTH-1:0]   w_clip_val;
    logic                          w_load;
    logic                          w_result_drop;
    logic                          w_pend_drop;
    logic                          w_sat_evt;
    logic                          w_ovr_evt;

    // A held pending sample is always consumed before a fresh strobe.
    assign w_idle        = (r_state == c_st_idle);
    assign w_accept      = w_idle && (r_pend_valid || in_valid);
    assign w_accept_data = r_pend_valid ? r_pend_data : in_data;
    assign w_phase_wrap  = c_no_decim || r_phase;
    assign w_trigger     = w_accept && w_phase_wrap;
    assign w_wptr_next   = (r_wptr == c_last_ptr) ? '0 : r_wptr + c_aw'(1);
    assign w_rptr_a_dec  = (r_rptr_a == '0) ? c_last_ptr : r_rptr_a - c_aw'(1);
    assign w_pend_drop   = in_valid && !w_idle && r_pend_valid;

    // ROM address runs one tap ahead so the registered coefficient lines up with r_k.
    assign w_rom_addr = (r_state == c_st_mac && r_k != c_mac_last) ? r_k + c_aw'(1) : '0;

    cic_comp_coef_rom #(
        .COEF_WIDTH (COEF_WIDTH),
        .DEPTH      (c_mac_cycles),
        .AW         (c_aw)
    ) u_rom (
        .clk    (clk),
        .i_addr (w_rom_addr),
        .o_coef (w_coef)
    );

    assign w_xa = r_line[r_rptr_a];

`ifdef CIC_COMP_FIR_SYMMETRIC_EN
    logic [c_aw-1:0]            r_rptr_b;
    logic signed [IN_WIDTH-1:0] w_xb;

    assign w_xb   = r_line[r_rptr_b];
    assign w_x_op = {w_xa[IN_WIDTH-1], w_xa} + {w_xb[IN_WIDTH-1], w_xb};

    // Walks forward from the oldest sample, mirroring r_rptr_a.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rptr_b <= '0;
        end else if (w_idle && w_trigger) begin
            r_rptr_b <= w_wptr_next;
        end else if (r_state == c_st_mac) begin
            r_rptr_b <= (r_rptr_b == c_last_ptr) ? '0 : r_rptr_b + c_aw'(1);
        end
    end
`else
    assign w_x_op = {w_xa[IN_WIDTH-1], w_xa};
`endif

    assign w_x_ext    = {{(c_pw - c_xw){w_x_op[c_xw-1]}}, w_x_op};
    assign w_c_ext    = {{(c_pw - COEF_WIDTH){w_coef[COEF_WIDTH-1]}}, w_coef};
    assign w_prod     = w_x_ext * w_c_ext;
    assign w_prod_ext = {{(ACC_WIDTH - c_pw){w_prod[c_pw-1]}}, w_prod};

    assign w_sum      = r_acc + c_half;
    assign w_shifted  = w_sum >>> SHIFT;
    assign w_clip_hi  = (w_shifted > c_out_max);
    assign w_clip_lo  = (w_shifted < c_out_min);
    assign w_clip_val = w_clip_hi ? {1'b0, {(OUT_WIDTH - 1){1'b1}}} :
                        w_clip_lo ? {1'b1, {(OUT_WIDTH - 1){1'b0}}} :
                                    w_shifted[OUT_WIDTH-1:0];

    // Consumer acceptance frees the output register in the same cycle.
    assign w_load        = (r_state == c_st_out) && (!r_out_valid || out_ready);
    assign w_result_drop = (r_state == c_st_out) && r_out_valid && !out_ready;
    assign w_sat_evt     = (r_state == c_st_round) && (w_clip_hi || w_clip_lo);
    assign w_ovr_evt     = w_pend_drop || w_result_drop;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++) begin
                r_line[i] <= '0;
            end
            r_wptr  <= '0;
            r_phase <= 1'b0;
        end else if (w_accept) begin
            r_line[r_wptr] <= w_accept_data;
            r_wptr         <= w_wptr_next;
            r_phase        <= ~w_phase_wrap;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_valid <= 1'b0;
            r_pend_data  <= '0;
        end else if (w_idle) begin
            if (r_pend_valid) begin
                r_pend_valid <= in_valid;
                if (in_valid) begin
                    r_pend_data <= in_data;
                end
            end
        end else if (in_valid && !r_pend_valid) begin
            r_pend_valid <= 1'b1;
            r_pend_data  <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_st_idle;
            r_k      <= '0;
            r_rptr_a <= '0;
            r_acc    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_trigger) begin
                        r_state  <= c_st_mac;
                        r_k      <= '0;
                        r_acc    <= '0;
                        r_rptr_a <= r_wptr;
                    end
                end
                c_st_mac: begin
                    r_acc    <= r_acc + w_prod_ext;
                    r_k      <= r_k + c_aw'(1);
                    r_rptr_a <= w_rptr_a_dec;
                    if (r_k == c_mac_last) begin
                        r_state <= c_st_round;
                    end
                end
                c_st_round: begin
                    r_result <= w_clip_val;
                    r_state  <= c_st_out;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            r_out_data  <= r_result;
            r_out_valid <= 1'b1;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // A flag event in the same cycle as clr_status keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overrun <= 1'b0;
            r_sat     <= 1'b0;
        end else begin
            if (w_ovr_evt) begin
                r_overrun <= 1'b1;
            end else if (clr_status) begin
                r_overrun <= 1'b0;
            end
            if (w_sat_evt) begin
                r_sat <= 1'b1;
            end else if (clr_status) begin
                r_sat <= 1'b0;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign overrun   = r_overrun;
    assign sat       = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_cic_comp_fir.sv
`default_nettype none
// ============================================================================
// Module      : tb_cic_comp_fir
// Description : Directed self-checking bench for cic_comp_fir (DECIM=1 and 2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cic_comp_fir;

`ifdef CIC_COMP_FIR_SYMMETRIC_EN
    localparam int LAT = 18;
`else
    localparam int LAT = 34;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic signed [31:0] in_data = '0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic clr_status = 1'b0;
    logic signed [15:0] out_data;
    logic out_valid, overrun, sat;
    logic signed [15:0] d2_out_data;
    logic d2_out_valid, d2_overrun, d2_sat;

    int n_checks = 0;
    int n_fail = 0;

    int tb_coef [32] = '{-10, -20, -30, -25, 0, 40, 80, 100, 60, -50, -200, -350,
                         -300, 200, 1500, 15389, 15389, 1500, 200, -300, -350, -200,
                         -50, 60, 100, 80, 40, 0, -25, -30, -20, -10};

    always #5 clk = ~clk;

    cic_comp_fir #(.DECIM(1)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .clr_status(clr_status), .overrun(overrun), .sat(sat)
    );

    cic_comp_fir #(.DECIM(2)) dut_d2 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .out_data(d2_out_data), .out_valid(d2_out_valid), .out_ready(out_ready),
        .clr_status(clr_status), .overrun(d2_overrun), .sat(d2_sat)
    );

    function automatic int exp_imp(input int k);
        if (k < 0 || k > 31) return 0;
        return (1000 * tb_coef[k] + 16384) >>> 15;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; clr_status = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic strobe(input int d);
        @(negedge clk);
        in_data = d; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Lat counts clock edges after the edge that captured the strobe.
    task automatic run_sample(input int d, output int y, output int lat);
        strobe(d);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        y = out_data;
        if (lat >= 200) begin
            n_checks++; n_fail++;
            $display("FAIL sample_timeout: no out_valid within %0d cycles", lat);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_data = 32'sd12345; out_ready = 1'b0;
        repeat (4) @(negedge clk);
        in_valid = 1'b0;
        n_checks++; if (out_data !== 16'sd0) begin n_fail++; $display("FAIL reset_out_data: got %0d want 0", out_data); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        n_checks++; if (sat !== 1'b0) begin n_fail++; $display("FAIL reset_sat: got %b want 0", sat); end
        n_checks++; if (d2_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_d2_out_valid: got %b want 0", d2_out_valid); end
        rst = 1'b0; out_ready = 1'b1;
    endtask

    task automatic test_dc();
        int y, lat;
        do_reset(); out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            run_sample(1000, y, lat);
            if (i == 0) begin
                n_checks++;
                if (lat !== LAT) begin n_fail++; $display("FAIL dc_latency: got %0d want %0d", lat, LAT); end
            end
            if (i >= 31) begin
                n_checks++;
                if (y !== 1000) begin n_fail++; $display("FAIL dc_value[%0d]: got %0d want 1000", i, y); end
            end
        end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL dc_handshake_clear: got %b want 0", out_valid); end
        n_checks++; if (sat !== 1'b0) begin n_fail++; $display("FAIL dc_sat: got %b want 0", sat); end
    endtask

    task automatic test_impulse();
        int y, lat;
        do_reset(); out_ready = 1'b1;
        for (int i = 0; i < 36; i++) begin
            run_sample((i == 0) ? 1000 : 0, y, lat);
            n_checks++;
            if (y !== exp_imp(i)) begin n_fail++; $display("FAIL impulse[%0d]: got %0d want %0d", i, y, exp_imp(i)); end
        end
    endtask

    task automatic test_saturation();
        int y, lat;
        do_reset(); out_ready = 1'b1;
        for (int i = 0; i < 33; i++) run_sample(1 << 20, y, lat);
        n_checks++; if (y !== 32767) begin n_fail++; $display("FAIL sat_pos_value: got %0d want 32767", y); end
        n_checks++; if (sat !== 1'b1) begin n_fail++; $display("FAIL sat_pos_flag: got %b want 1", sat); end
        @(negedge clk); clr_status = 1'b1;
        @(negedge clk); clr_status = 1'b0;
        n_checks++; if (sat !== 1'b0) begin n_fail++; $display("FAIL sat_clear: got %b want 0", sat); end
        run_sample(1 << 20, y, lat);
        n_checks++; if (sat !== 1'b1) begin n_fail++; $display("FAIL sat_reassert: got %b want 1", sat); end
        for (int i = 0; i < 33; i++) run_sample(-(1 << 20), y, lat);
        n_checks++; if (y !== -32768) begin n_fail++; $display("FAIL sat_neg_value: got %0d want -32768", y); end
        for (int i = 0; i < 33; i++) run_sample(0, y, lat);
        @(negedge clk); clr_status = 1'b1;
        @(negedge clk); clr_status = 1'b0;
        for (int i = 0; i < 3; i++) begin
            run_sample(0, y, lat);
            n_checks++; if (y !== 0) begin n_fail++; $display("FAIL sat_zero_value[%0d]: got %0d want 0", i, y); end
        end
        n_checks++; if (sat !== 1'b0) begin n_fail++; $display("FAIL sat_stays_clear: got %b want 0", sat); end
    endtask

    task automatic test_decimation();
        int n_out;
        int last;
        n_out = 0; last = 0;
        do_reset(); out_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            strobe(500);
            for (int c = 0; c < 40; c++) begin
                if (d2_out_valid === 1'b1) begin
                    n_out++; last = d2_out_data;
                    n_checks++;
                    if (c !== LAT || (i % 2) == 0) begin
                        n_fail++;
                        $display("FAIL decim_timing: strobe %0d out at %0d cycles, want odd strobe at %0d", i, c, LAT);
                    end
                end
                @(negedge clk);
            end
        end
        n_checks++; if (n_out !== 32) begin n_fail++; $display("FAIL decim_count: got %0d want 32", n_out); end
        n_checks++; if (last !== 500) begin n_fail++; $display("FAIL decim_value: got %0d want 500", last); end
    endtask

    task automatic test_backpressure();
        int y, lat;
        do_reset(); out_ready = 1'b1;
        for (int i = 0; i < 14; i++) run_sample((i == 0) ? 1000 : 0, y, lat);
        out_ready = 1'b0;
        strobe(0);
        repeat (LAT + 2) @(negedge clk);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_first_valid: got %b want 1", out_valid); end
        n_checks++; if (out_data !== exp_imp(14)) begin n_fail++; $display("FAIL bp_first_value: got %0d want %0d", out_data, exp_imp(14)); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL bp_no_overrun_yet: got %b want 0", overrun); end
        strobe(0);
        repeat (LAT + 2) @(negedge clk);
        n_checks++; if (out_data !== exp_imp(14)) begin n_fail++; $display("FAIL bp_held_value: got %0d want %0d", out_data, exp_imp(14)); end
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_held_valid: got %b want 1", out_valid); end
        n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL bp_overrun: got %b want 1", overrun); end
        @(negedge clk); out_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: got %b want 0", out_valid); end
    endtask

    task automatic test_overrun_reset();
        int n_out, n_stray;
        int vals [4];
        n_out = 0; n_stray = 0;
        do_reset(); out_ready = 1'b1;
        strobe(1000);
        repeat (3) @(negedge clk);
        strobe(0);
        repeat (3) @(negedge clk);
        strobe(5000);
        n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_flag: got %b want 1", overrun); end
        for (int c = 0; c < 120; c++) begin
            if (out_valid === 1'b1) begin
                if (n_out < 4) vals[n_out] = out_data;
                n_out++;
            end
            @(negedge clk);
        end
        n_checks++; if (n_out !== 2) begin n_fail++; $display("FAIL ovr_count: got %0d want 2", n_out); end
        if (n_out >= 2) begin
            n_checks++; if (vals[0] !== exp_imp(0)) begin n_fail++; $display("FAIL ovr_first_value: got %0d want %0d", vals[0], exp_imp(0)); end
            n_checks++; if (vals[1] !== exp_imp(1)) begin n_fail++; $display("FAIL ovr_pending_value: got %0d want %0d", vals[1], exp_imp(1)); end
        end
        strobe(2000);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (out_data !== 16'sd0) begin n_fail++; $display("FAIL midmac_out_data: got %0d want 0", out_data); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midmac_out_valid: got %b want 0", out_valid); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL midmac_overrun: got %b want 0", overrun); end
        for (int c = 0; c < 60; c++) begin
            if (out_valid === 1'b1) n_stray++;
            @(negedge clk);
        end
        n_checks++; if (n_stray !== 0) begin n_fail++; $display("FAIL midmac_stray_valid: got %0d want 0", n_stray); end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_dc();
        test_impulse();
        test_saturation();
        test_decimation();
        test_backpressure();
        test_overrun_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
